// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester (CPU / video) single-port RAM arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_CPU) ? OWN_VID : OWN_CPU;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// CPU / video arbiter for a single-port RAM with a 1-cycle registered read.
// Define MEM_ARBITER_RR_EN for round-robin contention; default is fixed VID priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int A = 12,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         cpu_rw,
    input  logic [A-1:0] cpu_addr,
    input  logic [D-1:0] cpu_wdata,
    output logic         cpu_ack,
    output logic [D-1:0] cpu_rdata,
    input  logic         vid_req,
    input  logic [A-1:0] vid_addr,
    output logic         vid_ack,
    output logic [D-1:0] vid_rdata,
    output logic         ram_cs,
    output logic         ram_rw,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_wdata,
    input  logic [D-1:0] ram_rdata
);

    state_e         state_r;
    state_e         state_nxt_s;
    owner_e         owner_r;
    owner_e         owner_nxt_s;
    owner_e         win_s;
    logic           other_req_s;
    logic           grant_s;
    logic           cs_nxt_s;
    logic           rw_nxt_s;
    logic [A-1:0]   addr_nxt_s;
    logic [D-1:0]   wdata_nxt_s;
    logic           cpu_ack_nxt_s;
    logic           vid_ack_nxt_s;

`ifdef MEM_ARBITER_RR_EN
    owner_e         rr_pref_r;

    // Round-robin winner: on contention the pointer names who goes first.
    always_comb begin
        win_s = OWN_VID;
        if (cpu_req && vid_req) begin
            win_s = rr_pref_r;
        end else if (vid_req) begin
            win_s = OWN_VID;
        end else begin
            win_s = OWN_CPU;
        end
    end

    // Pointer flips away from whoever was granted last.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_pref_r <= OWN_VID;
        end else if (grant_s) begin
            rr_pref_r <= other_owner(owner_nxt_s);
        end else begin
            rr_pref_r <= rr_pref_r;
        end
    end
`else
    // Fixed priority: video always wins contention.
    always_comb begin
        win_s = OWN_CPU;
        if (vid_req) begin
            win_s = OWN_VID;
        end else begin
            win_s = OWN_CPU;
        end
    end
`endif

    assign other_req_s = (owner_r == OWN_CPU) ? vid_req : cpu_req;

    // Next-state logic; in DONE the served requester's req is deliberately ignored.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        case (state_r)
            IDLE: begin
                if (cpu_req || vid_req) begin
                    state_nxt_s = ISSUE;
                    owner_nxt_s = win_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s = DONE;
            end
            DONE: begin
                if (other_req_s) begin
                    state_nxt_s = ISSUE;
                    owner_nxt_s = other_owner(owner_r);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign grant_s = (state_nxt_s == ISSUE);

    // Next values of the registered RAM-side and ack outputs.
    always_comb begin
        cs_nxt_s    = 1'b0;
        rw_nxt_s    = 1'b1;
        addr_nxt_s  = ram_addr;
        wdata_nxt_s = ram_wdata;
        if (grant_s) begin
            cs_nxt_s = 1'b1;
            if (owner_nxt_s == OWN_VID) begin
                rw_nxt_s    = 1'b1;
                addr_nxt_s  = vid_addr;
                wdata_nxt_s = {D{1'b0}};
            end else begin
                rw_nxt_s    = cpu_rw;
                addr_nxt_s  = cpu_addr;
                wdata_nxt_s = cpu_wdata;
            end
        end else begin
            cs_nxt_s = 1'b0;
            rw_nxt_s = 1'b1;
        end
        cpu_ack_nxt_s = (state_nxt_s == DONE) && (owner_nxt_s == OWN_CPU);
        vid_ack_nxt_s = (state_nxt_s == DONE) && (owner_nxt_s == OWN_VID);
    end

    // State, owner and all control outputs are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            owner_r   <= OWN_VID;
            ram_cs    <= 1'b0;
            ram_rw    <= 1'b1;
            ram_addr  <= {A{1'b0}};
            ram_wdata <= {D{1'b0}};
            cpu_ack   <= 1'b0;
            vid_ack   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            owner_r   <= owner_nxt_s;
            ram_cs    <= cs_nxt_s;
            ram_rw    <= rw_nxt_s;
            ram_addr  <= addr_nxt_s;
            ram_wdata <= wdata_nxt_s;
            cpu_ack   <= cpu_ack_nxt_s;
            vid_ack   <= vid_ack_nxt_s;
        end
    end

    // RAM read data arrives in DONE, the same cycle the ack is up.
    assign cpu_rdata = cpu_ack ? ram_rdata : {D{1'b0}};
    assign vid_rdata = vid_ack ? ram_rdata : {D{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural single-port RAM (1-cycle read).
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic       is_wr;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_rw = 1'b1;
    logic [11:0] cpu_addr = 12'h000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        vid_req = 1'b0;
    logic [11:0] vid_addr = 12'h000;
    logic        vid_ack;
    logic [7:0]  vid_rdata;
    logic        ram_cs, ram_rw;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = 12'h000;
    logic [7:0]  pre_data = 8'h00;
    logic [7:0]  mem    [0:4095];
    logic [7:0]  shadow [0:4095];

    exp_t cpu_q[$];
    exp_t vid_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.A(12), .D(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_cs && !ram_rw) begin
            mem[ram_addr] <= ram_wdata;
        end else if (ram_cs) begin
            ram_rdata <= mem[ram_addr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [11:0] addr, input logic [7:0] data);
        pre_en = 1'b1; pre_addr = addr; pre_data = data;
        shadow[addr] = data;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic cpu_start(input logic rw, input logic [11:0] addr, input logic [7:0] data);
        exp_t e;
        cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = data;
        e.is_wr = !rw;
        e.data  = shadow[addr];
        if (!rw) shadow[addr] = data;
        cpu_q.push_back(e);
    endtask

    task automatic vid_start(input logic [11:0] addr);
        exp_t e;
        vid_req = 1'b1; vid_addr = addr;
        e.is_wr = 1'b0;
        e.data  = shadow[addr];
        vid_q.push_back(e);
    endtask

    task automatic pulse_reset();
        reset = 1'b1; cpu_req = 1'b0; vid_req = 1'b0;
        cpu_q.delete(); vid_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ram_cs, ram_rw, ram_addr, ram_wdata} !== {1'b0, 1'b1, 12'h000, 8'h00}) begin
            n_err++;
            $display("FAIL reset_ram: got cs=%b rw=%b addr=%h wd=%h want 0 1 000 00", ram_cs, ram_rw, ram_addr, ram_wdata);
        end
        n_cmp++;
        if ({cpu_ack, vid_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ack: got %b want 00", {cpu_ack, vid_ack});
        end
        reset = 1'b0;
        for (int i = 0; i < 16; i++) preload(12'h800 + 12'(i), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 256; i++) preload(12'(i), 8'(i) ^ 8'h5A);
    endtask

    task automatic test_cpu_write_read();
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) cpu_start(1'b0, 12'h005, 8'hA5);
            else           cpu_start(1'b1, 12'h005, 8'h00);
            @(negedge clk);
            n_cmp++;
            if ({ram_cs, ram_rw, ram_addr, cpu_ack} !== {1'b1, pass[0], 12'h005, 1'b0}) begin
                n_err++;
                $display("FAIL cpu_issue%0d: got cs=%b rw=%b addr=%h ack=%b want 1 %0d 005 0", pass, ram_cs, ram_rw, ram_addr, cpu_ack, pass);
            end
            if (pass == 0) begin
                n_cmp++;
                if (ram_wdata !== 8'hA5) begin
                    n_err++;
                    $display("FAIL cpu_wdata: got %h want a5", ram_wdata);
                end
            end
            @(negedge clk);
            n_cmp++;
            if ({ram_cs, cpu_ack, vid_ack} !== 3'b010) begin
                n_err++;
                $display("FAIL cpu_done%0d: got cs=%b cack=%b vack=%b want 0 1 0", pass, ram_cs, cpu_ack, vid_ack);
            end
            if (cpu_q.size() > 0) begin
                e = cpu_q.pop_front();
                if (!e.is_wr) begin
                    n_cmp++;
                    if (cpu_rdata !== e.data || cpu_rdata !== 8'hA5) begin
                        n_err++;
                        $display("FAIL cpu_rdata: got %h want %h", cpu_rdata, e.data);
                    end
                end
            end
            cpu_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_vid_read();
        exp_t e;
        preload(12'h0FF, 8'h3C);
        vid_start(12'h0FF);
        @(negedge clk);
        n_cmp++;
        if ({ram_cs, ram_rw, ram_addr, ram_wdata, vid_ack} !== {1'b1, 1'b1, 12'h0FF, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL vid_issue: got cs=%b rw=%b addr=%h wd=%h ack=%b", ram_cs, ram_rw, ram_addr, ram_wdata, vid_ack);
        end
        @(negedge clk);
        e = vid_q.pop_front();
        n_cmp++;
        if ({vid_ack, cpu_ack, vid_rdata} !== {1'b1, 1'b0, e.data}) begin
            n_err++;
            $display("FAIL vid_done: got vack=%b cack=%b rdata=%h want 1 0 %h", vid_ack, cpu_ack, vid_rdata, e.data);
        end
        vid_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({vid_ack, cpu_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL vid_one_cycle: got vack=%b cack=%b want 0 0", vid_ack, cpu_ack);
        end
    endtask

    task automatic test_contention();
        exp_t e;
        int   vid_at, cpu_at;
        pulse_reset();
        vid_at = 0; cpu_at = 0;
        cpu_start(1'b1, 12'h801, 8'h00);
        vid_start(12'h010);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (vid_ack) begin
                vid_at = k;
                e = vid_q.pop_front();
                n_cmp++;
                if (vid_rdata !== e.data) begin
                    n_err++;
                    $display("FAIL cont_vid_data: got %h want %h", vid_rdata, e.data);
                end
                vid_req = 1'b0;
            end
            if (cpu_ack) begin
                cpu_at = k;
                e = cpu_q.pop_front();
                n_cmp++;
                if (cpu_rdata !== e.data) begin
                    n_err++;
                    $display("FAIL cont_cpu_data: got %h want %h", cpu_rdata, e.data);
                end
                cpu_req = 1'b0;
            end
        end
        n_cmp++;
        if (vid_at !== 2 || cpu_at !== 4) begin
            n_err++;
            $display("FAIL cont_order: got vid@%0d cpu@%0d want vid@2 cpu@4", vid_at, cpu_at);
        end
    endtask

    task automatic test_rr_pointer();
        owner_e first, want;
        exp_t   e;
        int     acks;
`ifdef MEM_ARBITER_RR_EN
        want = OWN_CPU;
`else
        want = OWN_VID;
`endif
        pulse_reset();
        vid_start(12'h020);
        repeat (2) @(negedge clk);
        void'(vid_q.pop_front());
        vid_req = 1'b0;
        @(negedge clk);
        cpu_start(1'b1, 12'h802, 8'h00);
        vid_start(12'h021);
        acks = 0; first = OWN_CPU;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (vid_ack) begin
                if (acks == 0) first = OWN_VID;
                acks++;
                e = vid_q.pop_front();
                vid_req = 1'b0;
            end
            if (cpu_ack) begin
                if (acks == 0) first = OWN_CPU;
                acks++;
                e = cpu_q.pop_front();
                cpu_req = 1'b0;
            end
        end
        n_cmp++;
        if (acks !== 2 || first !== want) begin
            n_err++;
            $display("FAIL rr_pointer: got acks=%0d first=%s want 2 %s", acks, first.name(), want.name());
        end
    endtask

    task automatic test_back_to_back();
        owner_e order [4];
        exp_t   e;
        int     grants;
        order = '{OWN_VID, OWN_CPU, OWN_VID, OWN_CPU};
        pulse_reset();
        grants = 0;
        cpu_start(1'b1, 12'h803, 8'h00);
        vid_start(12'h030);
        for (int k = 1; k <= 12 && grants < 4; k++) begin
            @(negedge clk);
            if (vid_ack || cpu_ack) begin
                n_cmp++;
                if ((vid_ack ? OWN_VID : OWN_CPU) !== order[grants] || k !== 2 + 2 * grants) begin
                    n_err++;
                    $display("FAIL b2b_order%0d: got vack=%b cack=%b at %0d want %s at %0d",
                             grants, vid_ack, cpu_ack, k, order[grants].name(), 2 + 2 * grants);
                end
                if (vid_ack) begin
                    e = vid_q.pop_front();
                    n_cmp++;
                    if (vid_rdata !== e.data) begin
                        n_err++;
                        $display("FAIL b2b_vid_data: got %h want %h", vid_rdata, e.data);
                    end
                    vid_start(12'h030);
                end else begin
                    e = cpu_q.pop_front();
                    n_cmp++;
                    if (cpu_rdata !== e.data) begin
                        n_err++;
                        $display("FAIL b2b_cpu_data: got %h want %h", cpu_rdata, e.data);
                    end
                    cpu_start(1'b1, 12'h803, 8'h00);
                end
                grants++;
            end
        end
        n_cmp++;
        if (grants !== 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d grants want 4", grants);
        end
        pulse_reset();
    endtask

    task automatic test_reset_mid_issue();
        cpu_start(1'b1, 12'h804, 8'h00);
        @(negedge clk);
        n_cmp++;
        if (ram_cs !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_issue: got cs=%b want 1", ram_cs);
        end
        reset = 1'b1; cpu_req = 1'b0;
        cpu_q.delete();
        @(negedge clk);
        n_cmp++;
        if ({ram_cs, ram_rw, ram_addr, cpu_ack, vid_ack} !== {1'b0, 1'b1, 12'h000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_mid_out: got cs=%b rw=%b addr=%h cack=%b vack=%b", ram_cs, ram_rw, ram_addr, cpu_ack, vid_ack);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ram_cs, cpu_ack, vid_ack} !== 3'b000 || dut.state_r !== IDLE) begin
            n_err++;
            $display("FAIL rst_mid_after: got cs=%b cack=%b vack=%b state=%0d want 0 0 0 IDLE", ram_cs, cpu_ack, vid_ack, dut.state_r);
        end
    endtask

    task automatic test_random();
        exp_t e;
        int   cpu_wait, vid_wait;
        logic prev_cs;
        cpu_wait = 0; vid_wait = 0; prev_cs = 1'b0;
        for (int i = 0; i < 1010; i++) begin
            @(negedge clk);
            n_cmp++;
            if (cpu_ack && vid_ack) begin
                n_err++;
                $display("FAIL rnd_ack_excl: cycle %0d got both acks", i);
            end
            n_cmp++;
            if (ram_cs && prev_cs) begin
                n_err++;
                $display("FAIL rnd_cs_consec: cycle %0d got cs high twice", i);
            end
            prev_cs = ram_cs;
            if (cpu_ack) begin
                n_cmp++;
                if (!cpu_req || cpu_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rnd_cpu_spurious: cycle %0d got ack with no request", i);
                end else begin
                    e = cpu_q.pop_front();
                    if (!e.is_wr && cpu_rdata !== e.data) begin
                        n_err++;
                        $display("FAIL rnd_cpu_data: got %h want %h", cpu_rdata, e.data);
                    end
                end
                cpu_req = 1'b0; cpu_wait = 0;
            end else if (cpu_req) begin
                cpu_wait++;
                if (cpu_wait > 3) begin
                    n_cmp++; n_err++;
                    $display("FAIL rnd_cpu_latency: cycle %0d got wait %0d want <=4", i, cpu_wait + 1);
                end
            end else if (i < 1000 && $urandom_range(0, 2) == 0) begin
                cpu_start(1'($urandom_range(0, 1)), 12'h800 + 12'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            end
            if (vid_ack) begin
                n_cmp++;
                if (!vid_req || vid_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rnd_vid_spurious: cycle %0d got ack with no request", i);
                end else begin
                    e = vid_q.pop_front();
                    if (vid_rdata !== e.data) begin
                        n_err++;
                        $display("FAIL rnd_vid_data: got %h want %h", vid_rdata, e.data);
                    end
                end
                vid_req = 1'b0; vid_wait = 0;
            end else if (vid_req) begin
                vid_wait++;
                if (vid_wait > 3) begin
                    n_cmp++; n_err++;
                    $display("FAIL rnd_vid_latency: cycle %0d got wait %0d want <=4", i, vid_wait + 1);
                end
            end else if (i < 1000 && $urandom_range(0, 1) == 0) begin
                vid_start(12'($urandom_range(0, 255)));
            end
        end
        n_cmp++;
        if (cpu_q.size() != 0 || vid_q.size() != 0) begin
            n_err++;
            $display("FAIL rnd_drain: got %0d cpu / %0d vid outstanding want 0", cpu_q.size(), vid_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_vid_read();
        test_contention();
        test_rr_pointer();
        test_back_to_back();
        test_reset_mid_issue();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter A, default 12, RAM address width in bits.
REQ-002 Parameter D, default 8, RAM data width in bits.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_req  in  1  CPU access request; held with cpu_rw/cpu_addr/cpu_wdata stable until cpu_ack.
REQ-006 cpu_rw  in  1  1=read, 0=write.
REQ-007 cpu_addr  in  A  CPU address.
REQ-008 cpu_wdata  in  D  CPU write data.
REQ-009 cpu_ack  out  1  one-cycle completion pulse.
REQ-010 cpu_rdata  out  D  read data, valid only while cpu_ack=1.
REQ-011 vid_req  in  1  video fetch request (read-only); held with vid_addr stable until vid_ack.
REQ-012 vid_addr  in  A  video fetch address.
REQ-013 vid_ack  out  1  one-cycle completion pulse.
REQ-014 vid_rdata  out  D  fetch data, valid only while vid_ack=1.
REQ-015 ram_cs, ram_rw, ram_addr[A], ram_wdata[D]  out  to single-port RAM (1-cycle registered read).
REQ-016 ram_rdata  in  D  RAM read data.

Function
REQ-017 FSM states IDLE, ISSUE, DONE; owner register selects CPU or VID.
REQ-018 IDLE: if any req high, select winner, go ISSUE; else stay IDLE.
REQ-019 ISSUE (one cycle): ram_cs=1; ram_addr/ram_rw/ram_wdata from owner (VID: ram_rw=1, ram_wdata=0); go DONE.
REQ-020 DONE (one cycle): ram_cs=0; owner's ack=1; owner's rdata=ram_rdata; other ack=0.
REQ-021 DONE: served requester's req ignored this cycle; if other req high, grant it and go ISSUE directly; else IDLE.
REQ-022 Latency: req high at edge N in IDLE -> ram_cs in cycle N+1 -> ack in cycle N+2; sustained throughput one access per 2 cycles.
REQ-023 Writes complete identically (ack in DONE); rdata of a write ack is don't-care.
REQ-024 Simultaneous cpu_req and vid_req in IDLE: winner per Configuration; loser served next (DONE->ISSUE), never dropped.
REQ-025 ram_cs=0 and ram_rw=1 in IDLE and DONE; both acks never high together.
REQ-026 Requester deasserting req before ack is a protocol violation; no recovery behaviour required.

Reset
REQ-027 reset high at any edge, including mid-ISSUE/DONE: state=IDLE, ram_cs=0, ram_rw=1, ram_addr=0, ram_wdata=0, cpu_ack=0, vid_ack=0, RR pointer=VID-first; in-flight access abandoned, no ack.
REQ-028 First grant possible at the edge after reset deasserts.

Configuration
REQ-029 Macro MEM_ARBITER_RR_EN defined: round-robin; 1-bit pointer favours requester not most recently granted on contention.
REQ-030 Macro undefined: fixed priority, VID always wins contention; no pointer register.

Structure
REQ-031 Package mem_arb_pkg holds state enum (IDLE/ISSUE/DONE) and owner enum (OWN_CPU/OWN_VID).
REQ-032 Single module; no sub-module.

Verification
REQ-033 CPU write addr 0x005 data 0xA5, then read 0x005 -> ram_cs in cycle N+1, cpu_ack cycle N+2, cpu_rdata=0xA5.
REQ-034 cpu_req and vid_req rise same edge, RR undefined -> vid_ack at N+2, cpu_ack at N+4.
REQ-035 With MEM_ARBITER_RR_EN, both held continuously for 4 grants -> ack order VID,CPU,VID,CPU.
REQ-036 vid_req alone at 0x0FF preloaded 0x3C -> vid_ack one cycle, vid_rdata=0x3C, cpu_ack stays 0.
REQ-037 reset asserted during ISSUE -> no ack, ram_cs=0 next cycle, state IDLE.
REQ-038 Random req traffic 1000 cycles -> acks mutually exclusive, ram_cs never two consecutive cycles, every req acked within 4 cycles.
